tl_link_monitor: RTL and testbench
==================================

TL_LINK_MONITOR -- requirements
Module: tl_link_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, A-channel address width.
REQ-002 SHALL have parameter SRC_W, default 2, source-ID width; the tracker holds NSRC = 2^SRC_W entries.
REQ-003 SHALL have parameter SIZE_W, default 4, log2 transfer-size field width.
REQ-004 SHALL have parameter BEAT_LG, default 3, log2 of bytes per data beat.
REQ-005 SHALL have parameter TIMEOUT, default 1024, the number of cycles without D progress allowed while any request is inflight.
REQ-006 SHALL have ports, in order: clock in 1, single clock; reset_n in 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports: a_valid in 1; a_ready in 1; a_opcode in 3; a_size in SIZE_W; a_source in SRC_W; a_address in ADDR_W.
REQ-008 SHALL have ports: d_valid in 1; d_ready in 1; d_opcode in 3; d_size in SIZE_W; d_source in SRC_W.
REQ-009 SHALL have port err_clear in 1: a synchronous pulse that clears all sticky error state.
REQ-010 SHALL have outputs: err_vec out 8, sticky per-check flags; err_any out 1, OR of err_vec; first_err out 3, index of the first error raised; inflight_cnt out SRC_W+1, number of busy sources.

Function
REQ-011 A handshake fires on a_valid&a_ready; D handshake fires on d_valid&d_ready; the monitor is passive and drives no channel signal.
REQ-012 Beat count SHALL be 2^(size-BEAT_LG) for size>BEAT_LG, else 1.
- A beats: only opcodes 0 (PutFull) and 1 (PutPartial) carry beats.
- D beats: only opcode 1 (AccessAckData) carries beats.
REQ-013 Per-channel beat counters SHALL track multi-beat bursts; beats after the first SHALL NOT be treated as new requests or responses.
REQ-014 The tracker SHALL record busy[src] and size[src] on the first A beat fire; it SHALL clear busy[src] on the last D beat fire.
REQ-015 A-first-beat set and D-last-beat clear on the same source in the same cycle SHALL leave the entry busy with the new size, and SHALL NOT raise an error.
REQ-016 err_vec bit 0, A_UNSTABLE: set when a_valid was high and unfired in the previous cycle, and this cycle a_valid drops or opcode/size/source/address changes.
REQ-017 err_vec bit 1, A_SRC_BUSY: set on an A first beat whose source is busy and not being cleared in the same cycle.
REQ-018 err_vec bit 2, A_MISALIGN: set on an A first beat where address bits below a_size are nonzero (bits below min(a_size, ADDR_W)).
REQ-019 err_vec bit 3, D_UNSTABLE: same rule as bit 0, applied to the D fields.
REQ-020 err_vec bit 4, D_NO_REQ: set on a D first beat whose source is not busy.
REQ-021 err_vec bit 5, D_SIZE_MISMATCH: set on a D first beat where d_size differs from size[d_source].
REQ-022 err_vec bit 6, TIMEOUT: a stall counter SHALL increment each cycle with inflight_cnt>0 and no D fire, and SHALL reset to 0 on any D fire or when inflight_cnt=0; the bit sets when the counter reaches TIMEOUT, and the counter saturates there.
REQ-023 err_vec bit 7, A_OPCODE: set on an A first beat whose opcode is not in {0,1,4}.
REQ-024 err_vec bits SHALL become visible one cycle after the offending handshake or cycle (registered), and SHALL remain set until err_clear or reset.
REQ-025 first_err SHALL latch the lowest set index among the new errors only when err_vec was all zero; on err_clear it SHALL return to 0.
REQ-026 An error event coincident with err_clear SHALL win: it is recorded after the clear.
REQ-027 inflight_cnt SHALL equal popcount(busy), registered, and SHALL never exceed NSRC.

Reset
REQ-028 On reset_n low, asynchronously: busy, beat counters, stall counter, err_vec, first_err and inflight_cnt SHALL be 0; size[] is don't-care.
REQ-029 Stability history SHALL reset to "no pending valid", so no UNSTABLE error fires in the first cycle after reset release.
REQ-030 Reset asserted mid-burst SHALL discard all tracking; no error SHALL be raised for the abandoned transaction.

Structure
REQ-031 Opcode constants, error-bit indices and the beat-count function SHALL live in package tl_mon_pkg.
REQ-032 One sub-module, tl_mon_src_table (busy/size storage with set/clear ports and popcount), is natural; all other logic stays in the top module.

Verification
REQ-033 Get, src 2, size 3, addr 0x100; AccessAckData d_size 3 after 4 cycles -> inflight_cnt 1 then 0; err_vec 0.
REQ-034 PutFull size 5 (4 beats), a_ready low for 2 cycles holding the fields -> one tracker entry; a 4th-beat D AccessAck clears it; err_vec 0.
REQ-035 Get src 1 addr 0x102 size 2 -> err_vec 0x04, first_err 2; then err_clear -> err_vec 0, first_err 0.
REQ-036 D AccessAck on idle src 3 with a_valid dropped while stalled in the same test -> err_vec 0x11, first_err 0.
REQ-037 Get src 0, no D for TIMEOUT=16 cycles -> err_vec bit 6 set at cycle 16+1; same-cycle D-last/A-first on src 0 -> no error.

Source files
------------

// File: rtl/tl_mon_pkg.sv
// -----------------------------------------------------------------------------
// tl_mon_pkg
// Shared constants and helpers for the TileLink link monitor:
//   - A/D channel opcode encodings the monitor cares about
//   - err_vec bit indices
//   - beat-count and opcode-class helper functions
// -----------------------------------------------------------------------------
package tl_mon_pkg;

    // A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    // err_vec bit positions
    localparam int ERR_A_UNSTABLE      = 0;
    localparam int ERR_A_SRC_BUSY      = 1;
    localparam int ERR_A_MISALIGN      = 2;
    localparam int ERR_D_UNSTABLE      = 3;
    localparam int ERR_D_NO_REQ        = 4;
    localparam int ERR_D_SIZE_MISMATCH = 5;
    localparam int ERR_TIMEOUT         = 6;
    localparam int ERR_A_OPCODE        = 7;
    localparam int NUM_ERR             = 8;

    // Number of data beats for a transfer of 2^size bytes on a 2^beat_lg byte bus
    function automatic int unsigned beat_count(input int unsigned size,
                                               input int unsigned beat_lg);
        if (size > beat_lg) begin
            return 32'd1 << (size - beat_lg);
        end
        return 32'd1;
    endfunction

    function automatic logic a_has_data(input logic [2:0] op);
        return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL);
    endfunction

    function automatic logic d_has_data(input logic [2:0] op);
        return (op == D_ACCESS_ACK_DATA);
    endfunction

    function automatic logic a_opcode_legal(input logic [2:0] op);
        return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL) || (op == A_GET);
    endfunction

endpackage

// File: rtl/tl_mon_src_table.sv
// -----------------------------------------------------------------------------
// tl_mon_src_table
// Per-source request tracker: one busy bit and one recorded size per source ID.
// Ports:
//   clock, reset_n          - clock, async active-low reset (clears busy/count)
//   set_en/set_src/set_size - mark a source busy and record its size
//   clr_en/clr_src          - release a source
//   a_src -> a_busy         - busy lookup for the A channel
//   d_src -> d_busy, d_size - busy/size lookup for the D channel
//   busy_cnt                - registered popcount of busy
// A set and a clear on the same source in the same cycle leaves it busy.
// -----------------------------------------------------------------------------
module tl_mon_src_table #(
    parameter int SRC_W  = 2,
    parameter int SIZE_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic [SRC_W-1:0]  set_src,
    input  logic [SIZE_W-1:0] set_size,
    input  logic              clr_en,
    input  logic [SRC_W-1:0]  clr_src,
    input  logic [SRC_W-1:0]  a_src,
    output logic              a_busy,
    input  logic [SRC_W-1:0]  d_src,
    output logic              d_busy,
    output logic [SIZE_W-1:0] d_size,
    output logic [SRC_W:0]    busy_cnt
);

    localparam int NSRC = 1 << SRC_W;

    logic [NSRC-1:0]   busy_q;
    logic [NSRC-1:0]   busy_next;
    logic [SRC_W:0]    cnt_next;
    logic [SIZE_W-1:0] size_q [NSRC];

    // Clear first, then set, so a same-source swap stays busy
    always_comb begin
        busy_next = busy_q;
        if (clr_en) busy_next[clr_src] = 1'b0;
        if (set_en) busy_next[set_src] = 1'b1;
        cnt_next = '0;
        for (int i = 0; i < NSRC; i++) begin
            cnt_next = cnt_next + (SRC_W+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    // Size storage is only meaningful while busy, so it carries no reset
    always_ff @(posedge clock) begin
        if (set_en) size_q[set_src] <= set_size;
    end

    assign a_busy = busy_q[a_src];
    assign d_busy = busy_q[d_src];
    assign d_size = size_q[d_src];

endmodule

// File: rtl/tl_link_monitor.sv
// -----------------------------------------------------------------------------
// tl_link_monitor
// Passive TileLink-UL/UH protocol checker watching one A/D channel pair.
// Ports:
//   clock, reset_n                    - clock, async active-low reset
//   a_valid/a_ready/a_opcode/a_size/a_source/a_address - observed A channel
//   d_valid/d_ready/d_opcode/d_size/d_source           - observed D channel
//   err_clear    - synchronous pulse clearing the sticky error state
//   err_vec      - sticky per-check error flags (indices in tl_mon_pkg)
//   err_any      - OR of err_vec
//   first_err    - index of the first error raised since the last clear
//   inflight_cnt - number of source IDs with an outstanding request
// -----------------------------------------------------------------------------
module tl_link_monitor
    import tl_mon_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int SRC_W   = 2,
    parameter int SIZE_W  = 4,
    parameter int BEAT_LG = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    input  logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [SIZE_W-1:0] a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              d_valid,
    input  logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic [SIZE_W-1:0] d_size,
    input  logic [SRC_W-1:0]  d_source,
    input  logic              err_clear,
    output logic [7:0]        err_vec,
    output logic              err_any,
    output logic [2:0]        first_err,
    output logic [SRC_W:0]    inflight_cnt
);

    // Wide enough for the largest burst a SIZE_W size field can describe
    localparam int CNT_W   = ((1 << SIZE_W) > 31) ? 31 : (1 << SIZE_W);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    function automatic logic [2:0] lowest_set(input logic [NUM_ERR-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic a_fire, d_fire;
    assign a_fire = a_valid & a_ready;
    assign d_fire = d_valid & d_ready;

    // ---- Beat tracking: *_left counts beats still due after the current one
    logic [CNT_W-1:0] a_left, d_left, a_total, d_total;
    logic             a_first, d_first, d_last;

    assign a_total = a_has_data(a_opcode) ? CNT_W'(beat_count(32'(a_size), BEAT_LG)) : CNT_W'(1);
    assign d_total = d_has_data(d_opcode) ? CNT_W'(beat_count(32'(d_size), BEAT_LG)) : CNT_W'(1);
    assign a_first = (a_left == '0);
    assign d_first = (d_left == '0);
    assign d_last  = d_first ? (d_total == CNT_W'(1)) : (d_left == CNT_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_left <= '0;
            d_left <= '0;
        end else begin
            if (a_fire) a_left <= a_first ? (a_total - CNT_W'(1)) : (a_left - CNT_W'(1));
            if (d_fire) d_left <= d_first ? (d_total - CNT_W'(1)) : (d_left - CNT_W'(1));
        end
    end

    // ---- Source tracker
    logic              set_en, clr_en, a_busy, d_busy;
    logic [SIZE_W-1:0] d_size_rec;

    assign set_en = a_fire & a_first;
    assign clr_en = d_fire & d_last;

    tl_mon_src_table #(
        .SRC_W  (SRC_W),
        .SIZE_W (SIZE_W)
    ) u_src_table (
        .clock    (clock),
        .reset_n  (reset_n),
        .set_en   (set_en),
        .set_src  (a_source),
        .set_size (a_size),
        .clr_en   (clr_en),
        .clr_src  (d_source),
        .a_src    (a_source),
        .a_busy   (a_busy),
        .d_src    (d_source),
        .d_busy   (d_busy),
        .d_size   (d_size_rec),
        .busy_cnt (inflight_cnt)
    );

    // ---- Stage p1: previous-cycle channel snapshot for the stability checks
    logic              a_pend_p1, d_pend_p1;
    logic [2:0]        a_opcode_p1, d_opcode_p1;
    logic [SIZE_W-1:0] a_size_p1, d_size_p1;
    logic [SRC_W-1:0]  a_source_p1, d_source_p1;
    logic [ADDR_W-1:0] a_address_p1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_pend_p1 <= 1'b0;
            d_pend_p1 <= 1'b0;
        end else begin
            a_pend_p1 <= a_valid & ~a_ready;
            d_pend_p1 <= d_valid & ~d_ready;
        end
    end

    always_ff @(posedge clock) begin
        a_opcode_p1  <= a_opcode;
        a_size_p1    <= a_size;
        a_source_p1  <= a_source;
        a_address_p1 <= a_address;
        d_opcode_p1  <= d_opcode;
        d_size_p1    <= d_size;
        d_source_p1  <= d_source;
    end

    // ---- Stall counter: saturates at TIMEOUT while requests wait on D
    logic [STALL_W-1:0] stall_cnt;
    logic               stall_inc;

    assign stall_inc = (inflight_cnt != '0) & ~d_fire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (!stall_inc) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_W'(TIMEOUT)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    // ---- Error detection
    logic [ADDR_W-1:0]  a_mask;
    logic [NUM_ERR-1:0] err_new, err_base;

    always_comb begin
        a_mask = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            a_mask[i] = (i < int'(a_size));
        end
    end

    always_comb begin
        err_new = '0;
        err_new[ERR_A_UNSTABLE] = a_pend_p1 & (~a_valid | (a_opcode != a_opcode_p1) |
                                  (a_size != a_size_p1) | (a_source != a_source_p1) |
                                  (a_address != a_address_p1));
        // A same-cycle release of the source makes reuse legal
        err_new[ERR_A_SRC_BUSY] = set_en & a_busy & ~(clr_en & (d_source == a_source));
        err_new[ERR_A_MISALIGN] = set_en & ((a_address & a_mask) != '0);
        err_new[ERR_D_UNSTABLE] = d_pend_p1 & (~d_valid | (d_opcode != d_opcode_p1) |
                                  (d_size != d_size_p1) | (d_source != d_source_p1));
        err_new[ERR_D_NO_REQ]   = d_fire & d_first & ~d_busy;
        // The recorded size is meaningless for an idle source
        err_new[ERR_D_SIZE_MISMATCH] = d_fire & d_first & d_busy & (d_size != d_size_rec);
        err_new[ERR_TIMEOUT]    = (stall_cnt == STALL_W'(TIMEOUT));
        err_new[ERR_A_OPCODE]   = set_en & ~a_opcode_legal(a_opcode);
    end

    // ---- Stage p2: sticky error state; new events land after a coincident clear
    assign err_base = err_clear ? '0 : err_vec;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_vec   <= '0;
            first_err <= '0;
        end else begin
            err_vec <= err_base | err_new;
            if ((err_base == '0) && (err_new != '0)) begin
                first_err <= lowest_set(err_new);
            end else if (err_clear) begin
                first_err <= '0;
            end
        end
    end

    assign err_any = |err_vec;

endmodule

// File: tb/tb_tl_link_monitor.sv
module tb_tl_link_monitor;

    localparam int ADDR_W  = 32;
    localparam int SRC_W   = 2;
    localparam int SIZE_W  = 4;
    localparam int BEAT_LG = 3;
    localparam int TMO     = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              a_valid, a_ready;
    logic [2:0]        a_opcode;
    logic [SIZE_W-1:0] a_size;
    logic [SRC_W-1:0]  a_source;
    logic [ADDR_W-1:0] a_address;
    logic              d_valid, d_ready;
    logic [2:0]        d_opcode;
    logic [SIZE_W-1:0] d_size;
    logic [SRC_W-1:0]  d_source;
    logic              err_clear;
    logic [7:0]        err_vec;
    logic              err_any;
    logic [2:0]        first_err;
    logic [SRC_W:0]    inflight_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic [7:0] err;
        logic [2:0] first;
        logic [2:0] infl;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    tl_link_monitor #(
        .ADDR_W  (ADDR_W),
        .SRC_W   (SRC_W),
        .SIZE_W  (SIZE_W),
        .BEAT_LG (BEAT_LG),
        .TIMEOUT (TMO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_opcode     (a_opcode),
        .a_size       (a_size),
        .a_source     (a_source),
        .a_address    (a_address),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_opcode     (d_opcode),
        .d_size       (d_size),
        .d_source     (d_source),
        .err_clear    (err_clear),
        .err_vec      (err_vec),
        .err_any      (err_any),
        .first_err    (first_err),
        .inflight_cnt (inflight_cnt)
    );

    task automatic set_a(input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic [1:0] src, input logic [31:0] addr);
        a_valid = v; a_opcode = op; a_size = sz; a_source = src; a_address = addr;
    endtask

    task automatic set_d(input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic [1:0] src);
        d_valid = v; d_opcode = op; d_size = sz; d_source = src;
    endtask

    // Push the expected post-edge state, clock once, then pop and compare
    task automatic cyc(input string tag, input logic [7:0] e, input logic [2:0] f,
                       input logic [2:0] n);
        exp_t x;
        x.tag = tag; x.err = e; x.first = f; x.infl = n;
        sb.push_back(x);
        @(posedge clock);
        #1;
        x = sb.pop_front();
        tests++;
        assert (err_vec === x.err) else begin
            fails++;
            $error("FAIL %s err_vec observed=%h expected=%h", x.tag, err_vec, x.err);
        end
        tests++;
        assert (err_any === (|x.err)) else begin
            fails++;
            $error("FAIL %s err_any observed=%b expected=%b", x.tag, err_any, |x.err);
        end
        tests++;
        assert (first_err === x.first) else begin
            fails++;
            $error("FAIL %s first_err observed=%0d expected=%0d", x.tag, first_err, x.first);
        end
        tests++;
        assert (inflight_cnt === x.infl) else begin
            fails++;
            $error("FAIL %s inflight_cnt observed=%0d expected=%0d", x.tag, inflight_cnt, x.infl);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; err_clear = 1'b0; d_ready = 1'b1;
        a_ready = 1'b0;
        set_a(1, 3'd4, 4'd3, 2'd0, 32'h0);
        set_d(0, 3'd0, 4'd0, 2'd0);
        cyc("reset0", 8'h00, 3'd0, 3'd0);
        cyc("reset1", 8'h00, 3'd0, 3'd0);
        // release with a_valid dropped: history must be "no pending"
        reset_n = 1'b1; a_ready = 1'b1; a_valid = 1'b0;
        cyc("rst_release", 8'h00, 3'd0, 3'd0);

        // Get src2 size3, AccessAckData after 4 cycles
        set_a(1, 3'd4, 4'd3, 2'd2, 32'h100);
        cyc("get_a", 8'h00, 3'd0, 3'd1);
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc("get_wait", 8'h00, 3'd0, 3'd1);
        set_d(1, 3'd1, 4'd3, 2'd2);
        cyc("get_d", 8'h00, 3'd0, 3'd0);
        d_valid = 1'b0;

        // PutFull size5 = 4 beats, 2 stall cycles on the first beat
        set_a(1, 3'd0, 4'd5, 2'd1, 32'h40);
        a_ready = 1'b0;
        cyc("put_stall0", 8'h00, 3'd0, 3'd0);
        cyc("put_stall1", 8'h00, 3'd0, 3'd0);
        a_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc("put_beat", 8'h00, 3'd0, 3'd1);
        a_valid = 1'b0;
        set_d(1, 3'd0, 4'd5, 2'd1);
        cyc("put_ack", 8'h00, 3'd0, 3'd0);
        d_valid = 1'b0;

        // Misaligned Get, then clear
        set_a(1, 3'd4, 4'd2, 2'd1, 32'h102);
        cyc("misalign", 8'h04, 3'd2, 3'd1);
        a_valid = 1'b0; err_clear = 1'b1;
        cyc("misalign_clr", 8'h00, 3'd0, 3'd1);
        err_clear = 1'b0;
        set_d(1, 3'd1, 4'd2, 2'd1);
        cyc("misalign_d", 8'h00, 3'd0, 3'd0);
        d_valid = 1'b0;

        // Error coincident with err_clear survives the clear
        err_clear = 1'b1;
        set_a(1, 3'd4, 4'd1, 2'd1, 32'h101);
        cyc("clr_vs_err", 8'h04, 3'd2, 3'd1);
        err_clear = 1'b0; a_valid = 1'b0;
        set_d(1, 3'd1, 4'd1, 2'd1);
        cyc("clr_vs_err_d", 8'h04, 3'd2, 3'd0);
        d_valid = 1'b0; err_clear = 1'b1;
        cyc("clr2", 8'h00, 3'd0, 3'd0);
        err_clear = 1'b0;

        // A dropped while stalled + D on idle source, same cycle
        set_a(1, 3'd4, 4'd3, 2'd0, 32'h0);
        a_ready = 1'b0;
        cyc("unstab_hold", 8'h00, 3'd0, 3'd0);
        a_valid = 1'b0; a_ready = 1'b1;
        set_d(1, 3'd0, 4'd3, 2'd3);
        cyc("unstab_noreq", 8'h11, 3'd0, 3'd0);
        d_valid = 1'b0; err_clear = 1'b1;
        cyc("clr3", 8'h00, 3'd0, 3'd0);
        err_clear = 1'b0;

        // Timeout: Get src0, no D for TMO cycles
        set_a(1, 3'd4, 4'd3, 2'd0, 32'h0);
        cyc("tmo_a", 8'h00, 3'd0, 3'd1);
        a_valid = 1'b0;
        for (int i = 0; i < TMO; i++) cyc("tmo_quiet", 8'h00, 3'd0, 3'd1);
        cyc("tmo_hit", 8'h40, 3'd6, 3'd1);
        // same-cycle D-last / A-first on src0
        set_a(1, 3'd4, 4'd2, 2'd0, 32'h0);
        set_d(1, 3'd1, 4'd3, 2'd0);
        cyc("swap", 8'h40, 3'd6, 3'd1);
        a_valid = 1'b0; d_valid = 1'b0; err_clear = 1'b1;
        cyc("swap_clr", 8'h00, 3'd0, 3'd1);
        err_clear = 1'b0;
        set_d(1, 3'd1, 4'd2, 2'd0);
        cyc("swap_d", 8'h00, 3'd0, 3'd0);
        d_valid = 1'b0;

        // Reset mid-burst abandons tracking
        set_a(1, 3'd0, 4'd5, 2'd3, 32'h20);
        cyc("mid_b0", 8'h00, 3'd0, 3'd1);
        cyc("mid_b1", 8'h00, 3'd0, 3'd1);
        reset_n = 1'b0; a_valid = 1'b0;
        cyc("mid_rst", 8'h00, 3'd0, 3'd0);
        reset_n = 1'b1;
        set_a(1, 3'd4, 4'd3, 2'd3, 32'h0);
        cyc("mid_new_a", 8'h00, 3'd0, 3'd1);
        a_valid = 1'b0;
        set_d(1, 3'd1, 4'd3, 2'd3);
        cyc("mid_new_d", 8'h00, 3'd0, 3'd0);
        d_valid = 1'b0;

        // Illegal A opcode
        set_a(1, 3'd2, 4'd0, 2'd2, 32'h0);
        cyc("bad_op", 8'h80, 3'd7, 3'd1);
        a_valid = 1'b0;
        set_d(1, 3'd0, 4'd0, 2'd2);
        cyc("bad_op_d", 8'h80, 3'd7, 3'd0);
        d_valid = 1'b0; err_clear = 1'b1;
        cyc("clr4", 8'h00, 3'd0, 3'd0);
        err_clear = 1'b0;

        // D size mismatch
        set_a(1, 3'd4, 4'd3, 2'd1, 32'h0);
        cyc("sz_a", 8'h00, 3'd0, 3'd1);
        a_valid = 1'b0;
        set_d(1, 3'd1, 4'd2, 2'd1);
        cyc("sz_d", 8'h20, 3'd5, 3'd0);
        d_valid = 1'b0;

        // A on busy source (clear coincident with first request)
        err_clear = 1'b1;
        set_a(1, 3'd4, 4'd0, 2'd0, 32'h0);
        cyc("busy_a0", 8'h00, 3'd0, 3'd1);
        err_clear = 1'b0;
        cyc("busy_a1", 8'h02, 3'd1, 3'd1);
        a_valid = 1'b0;
        set_d(1, 3'd0, 4'd0, 2'd0);
        cyc("busy_d", 8'h02, 3'd1, 3'd0);

        // D instability while stalled
        d_ready = 1'b0;
        set_d(1, 3'd0, 4'd0, 2'd1);
        cyc("d_hold", 8'h02, 3'd1, 3'd0);
        d_source = 2'd2;
        cyc("d_change", 8'h0A, 3'd1, 3'd0);
        d_valid = 1'b0;
        cyc("d_drop", 8'h0A, 3'd1, 3'd0);
        d_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
